// File: rtl/lsu_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl_if
// Bundle of every handshake/bus signal of the memory-stage load/store
// controller: execute-side operation port, data-memory request/response port,
// and writeback/status outputs.
//
// Signals:
//   in_valid/in_ready/in_op/in_addr/in_wdata/in_rd   : operation from execute
//   mem_req_valid/mem_req_ready/mem_addr/mem_we/
//   mem_wstrb/mem_wdata                              : memory request
//   mem_rvalid/mem_rdata                             : memory load response
//   wb_valid/wb_rd/wb_data                           : load result to writeback
//   st_done                                          : store accepted pulse
//   fault/fault_addr                                 : misaligned-access pulse
//
// Modports:
//   slave  : the controller's view (lsu_mem_ctrl)
//   master : the surrounding core/memory view (execute, memory, writeback)
// -----------------------------------------------------------------------------
interface lsu_mem_ctrl_if #(
    parameter int RD_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic [63:0]     in_addr;
    logic [63:0]     in_wdata;
    logic [RD_W-1:0] in_rd;

    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [63:0]     mem_addr;
    logic            mem_we;
    logic [7:0]      mem_wstrb;
    logic [63:0]     mem_wdata;
    logic            mem_rvalid;
    logic [63:0]     mem_rdata;

    logic            wb_valid;
    logic [RD_W-1:0] wb_rd;
    logic [63:0]     wb_data;
    logic            st_done;
    logic            fault;
    logic [63:0]     fault_addr;

    modport slave (
        input  in_valid, in_op, in_addr, in_wdata, in_rd,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output in_ready,
        output mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        output wb_valid, wb_rd, wb_data, st_done, fault, fault_addr
    );

    modport master (
        output in_valid, in_op, in_addr, in_wdata, in_rd,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  in_ready,
        input  mem_req_valid, mem_addr, mem_we, mem_wstrb, mem_wdata,
        input  wb_valid, wb_rd, wb_data, st_done, fault, fault_addr
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// RV64 memory-stage load/store controller. Accepts one decoded memory
// operation from execute, issues a single-outstanding request to an
// 8-byte-aligned data-memory port with byte strobes, and returns sign- or
// zero-extended load results to writeback. Execute is stalled through
// in_ready while an access is in flight (IDLE -> REQ -> [RESP] -> IDLE).
//
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : lsu_mem_ctrl_if.slave (operation, memory and writeback signals)
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned H/W/D accesses raise a
//                          one-cycle fault with the offending address and no
//                          memory request is made. When undefined, the low
//                          address bits below the access size are ignored and
//                          fault/fault_addr are tied to zero.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int RD_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LD   = 4'd4,
        LSU_LBU  = 4'd5,
        LSU_LHU  = 4'd6,
        LSU_LWU  = 4'd7,
        LSU_SB   = 4'd8,
        LSU_SH   = 4'd9,
        LSU_SW   = 4'd10,
        LSU_SD   = 4'd11
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // ---------------------------------------------------------------- helpers
    function automatic logic op_is_load(input logic [3:0] op);
        case (op)
            LSU_LB, LSU_LH, LSU_LW, LSU_LD,
            LSU_LBU, LSU_LHU, LSU_LWU: op_is_load = 1'b1;
            default:                   op_is_load = 1'b0;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        case (op)
            LSU_SB, LSU_SH, LSU_SW, LSU_SD: op_is_store = 1'b1;
            default:                        op_is_store = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: op_size = SZ_B;
            LSU_LH, LSU_LHU, LSU_SH: op_size = SZ_H;
            LSU_LW, LSU_LWU, LSU_SW: op_size = SZ_W;
            default:                 op_size = SZ_D;
        endcase
    endfunction

    function automatic logic [7:0] size_strb(input logic [1:0] sz);
        case (sz)
            SZ_B:    size_strb = 8'h01;
            SZ_H:    size_strb = 8'h03;
            SZ_W:    size_strb = 8'h0F;
            default: size_strb = 8'hFF;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = off[0];
            SZ_W:    is_misaligned = |off[1:0];
            default: is_misaligned = |off;
        endcase
    endfunction
`else
    // Without the trap, bits below the access size are simply dropped so the
    // access lands on its naturally aligned container.
    function automatic logic [2:0] align_off(input logic [1:0] sz, input logic [2:0] off);
        case (sz)
            SZ_B:    align_off = off;
            SZ_H:    align_off = {off[2:1], 1'b0};
            SZ_W:    align_off = {off[2], 2'b00};
            default: align_off = 3'b000;
        endcase
    endfunction
`endif

    // Right-justify the addressed lane of the doubleword, then extend.
    function automatic logic [63:0] load_extract(input logic [3:0]  op,
                                                 input logic [2:0]  off,
                                                 input logic [63:0] rdata);
        logic [63:0] r;
        r = rdata >> {off, 3'b000};
        case (op)
            LSU_LB:  load_extract = {{56{r[7]}},  r[7:0]};
            LSU_LH:  load_extract = {{48{r[15]}}, r[15:0]};
            LSU_LW:  load_extract = {{32{r[31]}}, r[31:0]};
            LSU_LBU: load_extract = {56'd0, r[7:0]};
            LSU_LHU: load_extract = {48'd0, r[15:0]};
            LSU_LWU: load_extract = {32'd0, r[31:0]};
            default: load_extract = r;
        endcase
    endfunction

    // ------------------------------------------------------------ decode (IDLE)
    state_t      r_state;
    state_t      w_next;

    logic        w_is_load;
    logic        w_is_store;
    logic [1:0]  w_sz;
    logic [2:0]  w_off;
    logic        w_misal;

    logic        w_accept;
    logic        w_fault;
    logic        w_st_done;
    logic        w_wb;

    logic [3:0]      r_op;
    logic [2:0]      r_off;
    logic [RD_W-1:0] r_rd;

    logic            r_mem_we;
    logic [63:0]     r_mem_addr;
    logic [7:0]      r_mem_wstrb;
    logic [63:0]     r_mem_wdata;
    logic            r_wb_valid;
    logic [RD_W-1:0] r_wb_rd;
    logic [63:0]     r_wb_data;
    logic            r_st_done;

    assign w_is_load  = op_is_load(bus.in_op);
    assign w_is_store = op_is_store(bus.in_op);
    assign w_sz       = op_size(bus.in_op);

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_off   = bus.in_addr[2:0];
    assign w_misal = is_misaligned(w_sz, bus.in_addr[2:0]);
`else
    assign w_off   = align_off(w_sz, bus.in_addr[2:0]);
    assign w_misal = 1'b0;
`endif

    // -------------------------------------------------------------- FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_fault   = 1'b0;
        w_st_done = 1'b0;
        w_wb      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // NONE and unused codes fall through here and are dropped.
                if (bus.in_valid && (w_is_load || w_is_store)) begin
                    if (w_misal) begin
                        w_fault = 1'b1;
                    end else begin
                        w_accept = 1'b1;
                        w_next   = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (bus.mem_req_ready) begin
                    if (r_mem_we) begin
                        w_st_done = 1'b1;
                        w_next    = ST_IDLE;
                    end else begin
                        w_next    = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (bus.mem_rvalid) begin
                    w_wb   = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------ operation capture (accept)
    // Internal bookkeeping for the load return path; only read after a
    // capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= bus.in_op;
            r_off <= w_off;
            r_rd  <= bus.in_rd;
        end
    end

    // Memory request fields are registered at accept, so they are stable for
    // the whole REQ phase regardless of what execute does meanwhile.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wstrb <= '0;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_mem_we    <= w_is_store;
            r_mem_addr  <= {bus.in_addr[63:3], 3'b000};
            r_mem_wstrb <= w_is_store ? (size_strb(w_sz) << w_off) : 8'h00;
            r_mem_wdata <= bus.in_wdata << {w_off, 3'b000};
        end
    end

    // --------------------------------------------------- writeback / status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_st_done  <= 1'b0;
        end else begin
            r_wb_valid <= w_wb;
            r_st_done  <= w_st_done;
            if (w_wb) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= load_extract(r_op, r_off, bus.mem_rdata);
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic        r_fault;
    logic [63:0] r_fault_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault      <= 1'b0;
            r_fault_addr <= '0;
        end else begin
            r_fault <= w_fault;
            if (w_fault) begin
                r_fault_addr <= bus.in_addr;
            end
        end
    end

    assign bus.fault      = r_fault;
    assign bus.fault_addr = r_fault_addr;
`else
    assign bus.fault      = 1'b0;
    assign bus.fault_addr = 64'd0;
`endif

    // ---------------------------------------------------------------- outputs
    assign bus.in_ready      = (r_state == ST_IDLE);
    assign bus.mem_req_valid = (r_state == ST_REQ);
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_we        = r_mem_we;
    assign bus.mem_wstrb     = r_mem_wstrb;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_rd         = r_wb_rd;
    assign bus.wb_data       = r_wb_data;
    assign bus.st_done       = r_st_done;

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Memory stage load/store controller for the RV64 core. It accepts one decoded memory operation (`lsu_op_t`, address, store data, destination register) from execute. It drives a single-outstanding request/response data-memory port with 8-byte-aligned addresses and byte strobes. Load results are extracted, sign- or zero-extended to XLEN, and handed to writeback. The block stalls execute through `in_ready` while an access is in flight.

## Interface
- `RD_W`, 5, destination register index width
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, reset asynchronous active-low
- `in_valid`  in  1  operation offered by execute
- `in_ready`  out  1  block can accept an operation (high only in IDLE)
- `in_op`  in  4  `lsu_op_t` code
- `in_addr`  in  64  effective byte address
- `in_wdata`  in  64  store data, right-aligned
- `in_rd`  in  RD_W  load destination register
- `mem_req_valid`  out  1  memory request valid
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`  out  64  `{in_addr[63:3],3'b0}`
- `mem_we`  out  1  1 = store
- `mem_wstrb`  out  8  byte enables; 0 for loads
- `mem_wdata`  out  64  lane-shifted store data
- `mem_rvalid`  in  1  load data returned
- `mem_rdata`  in  64  aligned doubleword
- `wb_valid`  out  1  one-cycle pulse: load result valid
- `wb_rd`  out  RD_W  load destination
- `wb_data`  out  64  extended load result
- `st_done`  out  1  one-cycle pulse: store accepted by memory
- `fault`  out  1  one-cycle pulse: misaligned access (only with the macro; otherwise tied 0)
- `fault_addr`  out  64  offending address, valid with `fault`

## Operation
- States: IDLE, REQ, RESP.
- IDLE:
  - `in_ready`=1. On `in_valid`, capture op, addr, wdata, rd.
  - Codes LSU_NONE and 12–15 are accepted and dropped; the state stays IDLE.
  - A misaligned op with the trap enabled pulses `fault` and stays IDLE.
  - Any other valid op goes to REQ.
- REQ:
  - `mem_req_valid`=1. All `mem_*` outputs are held stable until `mem_req_ready`.
  - On handshake, a store pulses `st_done` next cycle and returns to IDLE.
  - On handshake, a load goes to RESP.
- RESP:
  - Waits for `mem_rvalid`.
  - On the cycle `mem_rvalid`=1, `wb_data`/`wb_rd` are registered and `wb_valid` pulses the following cycle.
  - Then returns to IDLE.
- `mem_rvalid` outside RESP is ignored.
- Offset `off`=addr[2:0].
  - Strobes: SB `8'h01<<off`, SH `8'h03<<off`, SW `8'h0F<<off`, SD `8'hFF`.
  - `mem_wdata` = `in_wdata << (8*off)`.
- Load extraction: `r = mem_rdata >> (8*off)`, then:
  - LB/LH/LW: sign-extend bit 7/15/31.
  - LBU/LHU/LWU: zero-extend.
  - LD: `r` unchanged.
- Natural alignment:
  - H requires off[0]=0.
  - W requires off[1:0]=0.
  - D requires off=0.
  - B is always aligned.

## Timing
- Reset values: state IDLE; `in_ready`=1 (combinational from state); all other outputs 0.
- Reset mid-operation abandons the access with no `wb_valid`/`st_done`.
- Operation accepted at cycle T:
  - `mem_req_valid` rises at T+1.
  - Store with immediate ready: `st_done` at T+2.
  - Load with immediate ready and `mem_rvalid` at T+2: `wb_valid` at T+3.
- Back-to-back accepts: next accept is at earliest the cycle `wb_valid`/`st_done` is high (state already IDLE).
- `wb_valid`, `st_done` and `fault` are exactly one cycle wide and mutually exclusive.
- `in_ready` is combinational from state only; it does not depend on `in_valid`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access issues no memory request.
  - `fault`=1 and `fault_addr`=in_addr at T+1.
  - No `wb_valid`/`st_done` is produced.
- Undefined:
  - No check logic; `fault`/`fault_addr` are tied 0.
  - Address bits below the access size are cleared before computing `off`, e.g. LW at 0x1006 accesses 0x1004.

## Test plan
- SB addr 0x2003 wdata 0xAB, mem_req_ready=1 -> `mem_addr`=0x2000, `mem_wstrb`=0x08, `mem_wdata[31:24]`=0xAB, `st_done` at T+2.
- LB addr 0x1005 (0x1006 for LHU), rdata 0x0000_80FF_0000_0000 -> LB: `wb_data`=0xFFFF_FFFF_FFFF_FF80; LHU at 0x1006: 0x0000_0000_0000_0000.
- LW addr 0x1004 (0x1000 for LD), rdata 0x8000_0001_1234_5678 -> LW `wb_data`=0xFFFF_FFFF_8000_0001; LD at 0x1000 returns rdata unchanged; `wb_rd` matches `in_rd`.
- mem_req_ready low 5 cycles -> `mem_*` stable, `in_ready`=0; rvalid delayed 3 cycles -> `wb_valid` once, one cycle.
- With macro: SD addr 0x1004 -> `fault`=1, `fault_addr`=0x1004, no `mem_req_valid`. Without macro: SD addr 0x1004 -> access 0x1000, strobe 0xFF.
- `rst_n` low while in RESP -> IDLE, no `wb_valid`; later stray `mem_rvalid` ignored; LSU_NONE accepted with no output.
